// File: rtl/dsc_pkg.sv
// Shared definitions for the stochastic-to-binary decoder pair:
// default width, FSM encoding and window-length helper.
`timescale 1ns/1ps
package dsc_pkg;

    localparam int DSC_BITS = 10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } dsc_state_t;

    localparam int DSC_WINDOW = 1 << DSC_BITS;

    function automatic int window_len(input int bits);
        return 1 << bits;
    endfunction

endpackage

// File: rtl/dsc_s2b_pair_if.sv
// Request/stream/result bundle between a stochastic sorting stage and its decoder.
`timescale 1ns/1ps
interface dsc_s2b_pair_if
    import dsc_pkg::*;
#(
    parameter int BITS = DSC_BITS
);

    logic            start;
    logic            sn_max_in;
    logic            sn_min_in;
    logic            busy;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] max_bin;
    logic [BITS-1:0] min_bin;
    logic            order_err;

    modport master (
        output start, sn_max_in, sn_min_in, out_ready,
        input  busy, out_valid, max_bin, min_bin, order_err
    );

    modport slave (
        input  start, sn_max_in, sn_min_in, out_ready,
        output busy, out_valid, max_bin, min_bin, order_err
    );

endinterface

// File: rtl/dsc_sat_acc.sv
// Ones-counter with synchronous clear; one guard bit lets a full window of
// ones be counted exactly, and the output clamps it to the all-ones word.
`timescale 1ns/1ps
module dsc_sat_acc
    import dsc_pkg::*;
#(
    parameter int BITS = DSC_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic            bit_in,
    output logic [BITS-1:0] sat_out
);

    logic [BITS:0] acc_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (clr) begin
            acc_reg <= '0;
        end else if (en && bit_in && !(&acc_reg)) begin
            acc_reg <= acc_reg + 1'b1;
        end
    end

    assign sat_out = acc_reg[BITS] ? {BITS{1'b1}} : acc_reg[BITS-1:0];

endmodule

// File: rtl/dsc_s2b_pair.sv
// Counts the OR (max) and AND (min) stochastic streams over one 2^BITS window
// and presents the binary pair with a valid/ready handshake.
`timescale 1ns/1ps
module dsc_s2b_pair
    import dsc_pkg::*;
#(
    parameter int BITS = DSC_BITS
) (
    input  logic          clk,
    input  logic          rst,
    dsc_s2b_pair_if.slave bus
);

    localparam logic [BITS-1:0] LAST_SAMPLE = BITS'(window_len(BITS) - 1);

    dsc_state_t      state_reg;
    dsc_state_t      state_next;
    logic [BITS-1:0] cnt_reg;
    logic            order_err_reg;
    logic            win_clr;
    logic            sample_en;
    logic [BITS-1:0] max_cnt;
    logic [BITS-1:0] min_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        win_clr    = 1'b0;
        sample_en  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                    win_clr    = 1'b1;
                end
            end
            RUN: begin
                sample_en = 1'b1;
                if (cnt_reg == LAST_SAMPLE) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // start is deliberately not looked at here, even alongside the handshake
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Wraps to zero on the terminal sample so the next window starts clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (win_clr) begin
            cnt_reg <= '0;
        end else if (sample_en) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            order_err_reg <= 1'b0;
        end else if (win_clr) begin
            order_err_reg <= 1'b0;
        end else if (sample_en && bus.sn_min_in && !bus.sn_max_in) begin
            order_err_reg <= 1'b1;
        end
    end

    dsc_sat_acc #(.BITS(BITS)) u_acc_max (
        .clk     (clk),
        .rst     (rst),
        .clr     (win_clr),
        .en      (sample_en),
        .bit_in  (bus.sn_max_in),
        .sat_out (max_cnt)
    );

    dsc_sat_acc #(.BITS(BITS)) u_acc_min (
        .clk     (clk),
        .rst     (rst),
        .clr     (win_clr),
        .en      (sample_en),
        .bit_in  (bus.sn_min_in),
        .sat_out (min_cnt)
    );

    // Accumulators only move in RUN, so the result persists after acceptance.
    assign bus.max_bin   = max_cnt;
    assign bus.min_bin   = min_cnt;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.order_err = order_err_reg;

endmodule

// File: tb/tb_dsc_s2b_pair.sv
// Directed checks of the stochastic decoder pair: reset, counting, saturation,
// order errors, handshake, asynchronous reset mid-window and a short random sweep.
`timescale 1ns/1ps
module tb_dsc_s2b_pair;
    import dsc_pkg::*;

    localparam int BITS = 10;
    localparam int WIN  = 1 << BITS;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    dsc_s2b_pair_if #(.BITS(BITS)) bus_if ();

    dsc_s2b_pair #(.BITS(BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Tasks enter and leave just after a falling edge.
    task automatic start_window();
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
    endtask

    // mode 0: comparator encoders sharing the sample index, gated OR/AND
    // mode 1: max stream stuck at 1, min stream stuck at 0
    // mode 2: all zero except min=1 at index a
    task automatic drive_samples(input int mode, input int a, input int b,
                                 input int first, input int last);
        for (int i = first; i <= last; i++) begin
            case (mode)
                0: begin
                    bus_if.sn_max_in = (i < a) || (i < b);
                    bus_if.sn_min_in = (i < a) && (i < b);
                end
                1: begin
                    bus_if.sn_max_in = 1'b1;
                    bus_if.sn_min_in = 1'b0;
                end
                default: begin
                    bus_if.sn_max_in = 1'b0;
                    bus_if.sn_min_in = (i == a);
                end
            endcase
            @(negedge clk);
        end
        bus_if.sn_max_in = 1'b0;
        bus_if.sn_min_in = 1'b0;
    endtask

    task automatic accept();
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        bus_if.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.start     = 1'b0;
        bus_if.sn_max_in = 1'b0;
        bus_if.sn_min_in = 1'b0;
        bus_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus_if.busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy: got %b want 0", bus_if.busy);
        end
        total++;
        if (bus_if.out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid: got %b want 0", bus_if.out_valid);
        end
        total++;
        if (bus_if.max_bin !== '0 || bus_if.min_bin !== '0) begin
            bad++; $display("FAIL reset_bins: got max=%0d min=%0d want 0/0", bus_if.max_bin, bus_if.min_bin);
        end
        total++;
        if (bus_if.order_err !== 1'b0) begin
            bad++; $display("FAIL reset_order_err: got %b want 0", bus_if.order_err);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("reset: checked idle outputs");
    endtask

    task automatic test_matched();
        start_window();
        drive_samples(0, 700, 300, 0, WIN - 2);
        total++;
        if (bus_if.out_valid !== 1'b0 || bus_if.busy !== 1'b1) begin
            bad++; $display("FAIL matched_early: got valid=%b busy=%b want 0/1", bus_if.out_valid, bus_if.busy);
        end
        drive_samples(0, 700, 300, WIN - 1, WIN - 1);
        total++;
        if (bus_if.out_valid !== 1'b1) begin
            bad++; $display("FAIL matched_latency: got valid=%b want 1", bus_if.out_valid);
        end
        total++;
        if (bus_if.max_bin !== 10'd700 || bus_if.min_bin !== 10'd300) begin
            bad++; $display("FAIL matched_bins: got max=%0d min=%0d want 700/300", bus_if.max_bin, bus_if.min_bin);
        end
        total++;
        if (bus_if.order_err !== 1'b0) begin
            bad++; $display("FAIL matched_order_err: got %b want 0", bus_if.order_err);
        end
        accept();
        total++;
        if (bus_if.out_valid !== 1'b0 || bus_if.busy !== 1'b0) begin
            bad++; $display("FAIL matched_accept: got valid=%b busy=%b want 0/0", bus_if.out_valid, bus_if.busy);
        end
        total++;
        if (bus_if.max_bin !== 10'd700 || bus_if.min_bin !== 10'd300) begin
            bad++; $display("FAIL matched_hold: got max=%0d min=%0d want 700/300", bus_if.max_bin, bus_if.min_bin);
        end
        $display("matched: a=700 b=300 -> max=%0d min=%0d", bus_if.max_bin, bus_if.min_bin);
    endtask

    task automatic test_saturation();
        start_window();
        drive_samples(1, 0, 0, 0, WIN - 1);
        total++;
        if (bus_if.out_valid !== 1'b1 || bus_if.max_bin !== 10'd1023 || bus_if.min_bin !== 10'd0) begin
            bad++; $display("FAIL saturation: got valid=%b max=%0d min=%0d want 1/1023/0",
                            bus_if.out_valid, bus_if.max_bin, bus_if.min_bin);
        end
        $display("saturation: max=%0d min=%0d", bus_if.max_bin, bus_if.min_bin);
        accept();
    endtask

    task automatic test_order();
        start_window();
        drive_samples(2, 100, 0, 0, WIN - 1);
        total++;
        if (bus_if.out_valid !== 1'b1 || bus_if.order_err !== 1'b1) begin
            bad++; $display("FAIL order_flag: got valid=%b order_err=%b want 1/1", bus_if.out_valid, bus_if.order_err);
        end
        total++;
        if (bus_if.max_bin !== 10'd0 || bus_if.min_bin !== 10'd1) begin
            bad++; $display("FAIL order_bins: got max=%0d min=%0d want 0/1", bus_if.max_bin, bus_if.min_bin);
        end
        accept();
        total++;
        if (bus_if.order_err !== 1'b1) begin
            bad++; $display("FAIL order_sticky: got %b want 1", bus_if.order_err);
        end
        start_window();
        total++;
        if (bus_if.order_err !== 1'b0 || bus_if.min_bin !== 10'd0) begin
            bad++; $display("FAIL order_clear_on_start: got order_err=%b min=%0d want 0/0", bus_if.order_err, bus_if.min_bin);
        end
        drive_samples(0, 0, 0, 0, WIN - 1);
        total++;
        if (bus_if.order_err !== 1'b0 || bus_if.max_bin !== 10'd0 || bus_if.min_bin !== 10'd0) begin
            bad++; $display("FAIL order_zero_window: got order_err=%b max=%0d min=%0d want 0/0/0",
                            bus_if.order_err, bus_if.max_bin, bus_if.min_bin);
        end
        accept();
        $display("order: violation flagged and cleared by next start");
    endtask

    task automatic test_handshake();
        int stall_bad;
        stall_bad = 0;
        start_window();
        drive_samples(0, 123, 456, 0, WIN - 1);
        for (int k = 0; k < 50; k++) begin
            bus_if.start     = k[0];
            bus_if.out_ready = 1'b0;
            @(negedge clk);
            total++;
            if (bus_if.out_valid !== 1'b1 || bus_if.busy !== 1'b1 ||
                bus_if.max_bin !== 10'd456 || bus_if.min_bin !== 10'd123) begin
                bad++; stall_bad++;
                $display("FAIL handshake_stall[%0d]: got valid=%b busy=%b max=%0d min=%0d want 1/1/456/123",
                         k, bus_if.out_valid, bus_if.busy, bus_if.max_bin, bus_if.min_bin);
            end
        end
        bus_if.start     = 1'b1;
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        bus_if.start     = 1'b0;
        bus_if.out_ready = 1'b0;
        total++;
        if (bus_if.out_valid !== 1'b0 || bus_if.busy !== 1'b0) begin
            bad++; $display("FAIL handshake_release: got valid=%b busy=%b want 0/0", bus_if.out_valid, bus_if.busy);
        end
        @(negedge clk);
        total++;
        if (bus_if.busy !== 1'b0) begin
            bad++; $display("FAIL handshake_start_ignored: got busy=%b want 0", bus_if.busy);
        end
        $display("handshake: 50 stalled cycles, %0d bad, released to idle", stall_bad);
    endtask

    task automatic test_mid_reset();
        start_window();
        drive_samples(0, 600, 200, 0, 399);
        total++;
        if (bus_if.busy !== 1'b1) begin
            bad++; $display("FAIL midreset_running: got busy=%b want 1", bus_if.busy);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus_if.busy !== 1'b0 || bus_if.out_valid !== 1'b0 || bus_if.max_bin !== '0 ||
            bus_if.min_bin !== '0 || bus_if.order_err !== 1'b0) begin
            bad++; $display("FAIL midreset_async: got busy=%b valid=%b max=%0d min=%0d err=%b want all 0",
                            bus_if.busy, bus_if.out_valid, bus_if.max_bin, bus_if.min_bin, bus_if.order_err);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_window();
        drive_samples(0, 512, 511, 0, WIN - 1);
        total++;
        if (bus_if.out_valid !== 1'b1 || bus_if.max_bin !== 10'd512 || bus_if.min_bin !== 10'd511) begin
            bad++; $display("FAIL midreset_fresh: got valid=%b max=%0d min=%0d want 1/512/511",
                            bus_if.out_valid, bus_if.max_bin, bus_if.min_bin);
        end
        $display("mid_reset: fresh window max=%0d min=%0d", bus_if.max_bin, bus_if.min_bin);
        accept();
    endtask

    task automatic test_random();
        int a, b;
        logic [BITS-1:0] exp_max, exp_min;
        bus_if.out_ready = 1'b1;
        for (int n = 0; n < 23; n++) begin
            case (n)
                0: begin a = 0;    b = 1023; end
                1: begin a = 1023; b = 1023; end
                2: begin a = 1;    b = 0;    end
                default: begin
                    a = int'($urandom_range(1023, 0));
                    b = int'($urandom_range(1023, 0));
                end
            endcase
            exp_max = BITS'((a > b) ? a : b);
            exp_min = BITS'((a > b) ? b : a);
            start_window();
            drive_samples(0, a, b, 0, WIN - 1);
            total++;
            if (bus_if.out_valid !== 1'b1 || bus_if.max_bin !== exp_max || bus_if.min_bin !== exp_min ||
                bus_if.order_err !== 1'b0) begin
                bad++; $display("FAIL random[%0d]: a=%0d b=%0d got valid=%b max=%0d min=%0d err=%b want 1/%0d/%0d/0",
                                n, a, b, bus_if.out_valid, bus_if.max_bin, bus_if.min_bin, bus_if.order_err,
                                exp_max, exp_min);
            end
            total++;
            if (bus_if.order_err === 1'b0 && !(bus_if.max_bin >= bus_if.min_bin)) begin
                bad++; $display("FAIL random_invariant[%0d]: got max=%0d min=%0d want max>=min",
                                n, bus_if.max_bin, bus_if.min_bin);
            end
            @(negedge clk);
            total++;
            if (bus_if.out_valid !== 1'b0) begin
                bad++; $display("FAIL random_accept[%0d]: got valid=%b want 0", n, bus_if.out_valid);
            end
            $display("random[%0d]: a=%0d b=%0d -> max=%0d min=%0d", n, a, b, bus_if.max_bin, bus_if.min_bin);
        end
        bus_if.out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_matched();
        test_saturation();
        test_order();
        test_handshake();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
